crc_slice_engine: RTL

CRC_SLICE_ENGINE -- requirements
Module: crc_slice_engine

---
 rtl/crc_pkg.sv | 24 ++
 rtl/crc_slice_table.sv | 22 ++
 rtl/crc_slice_engine.sv | 133 +++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared constants and the elaboration-time CRC table generator used by the
// slice-by-N CRC-32 engine.
package crc_pkg;

    // Widest input beat the engine supports, in bytes.
    localparam int MAX_DATA_BYTES = 8;

    // CRC (zero initial value, MSB-first, non-reflected) of one data byte
    // followed by zero_bytes zero bytes. Only called with constant arguments,
    // so every table is folded to constants at elaboration.
    function automatic logic [31:0] crc_table_entry(
        input logic [31:0] poly,
        input logic [7:0]  data_byte,
        input int          zero_bytes
    );
        logic [31:0] crc;
        crc = {data_byte, 24'h000000};
        for (int b = 0; b < 8 * (zero_bytes + 1); b++) begin
            crc = crc[31] ? ((crc << 1) ^ poly) : (crc << 1);
        end
        return crc;
    endfunction

endpackage

// File: rtl/crc_slice_table.sv
// One 256 x 32 CRC lookup table: entry b is the CRC of byte b followed by
// ZERO_BYTES zero bytes. Pure constant ROM with a combinational read port.
module crc_slice_table
    import crc_pkg::*;
#(
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter int          ZERO_BYTES = 0
) (
    input  logic [7:0]  index,
    output logic [31:0] entry
);

    logic [31:0] table_rom [256];

    for (genvar b = 0; b < 256; b++) begin : g_entry
        localparam logic [31:0] ENTRY = crc_table_entry(POLY, 8'(b), ZERO_BYTES);
        assign table_rom[b] = ENTRY;
    end

    assign entry = table_rom[index];

endmodule

// File: rtl/crc_slice_engine.sv
// Slice-by-DATA_BYTES CRC-32 engine. Absorbs one beat of up to DATA_BYTES
// bytes per clock and returns the frame CRC through a valid/ready result port.
// A pending unread result stalls the input side.
module crc_slice_engine
    import crc_pkg::*;
#(
    parameter int          DATA_BYTES = 4,
    parameter logic [31:0] POLY       = 32'h04C11DB7,
    parameter logic [31:0] INIT       = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT     = 32'h00000000,
    localparam int         NB_W       = $clog2(DATA_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic                    s_last,
    input  logic [NB_W-1:0]         s_nbytes,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [31:0]             m_crc
);

    logic [31:0] crc;
    logic        ready_en;
    logic        accept;
    logic [3:0]  n_eff;
    logic [31:0] crc_next;
    logic [7:0]  data_byte [MAX_DATA_BYTES];
    logic [7:0]  crc_byte  [MAX_DATA_BYTES];
    logic [7:0]  tbl_idx   [DATA_BYTES];
    logic [31:0] tbl_out   [DATA_BYTES];

    // ready_en keeps s_ready low until the first clock after reset release.
    assign s_ready = ready_en && !clear && !(m_valid && !m_ready);
    assign accept  = s_valid && s_ready;

    // Byte lanes: byte 0 is the first byte on the wire (top of s_data).
    // Only the top four bytes of the register fold into the first lanes.
    for (genvar i = 0; i < MAX_DATA_BYTES; i++) begin : g_lane
        if (i < DATA_BYTES) begin : g_data
            assign data_byte[i] = s_data[8*DATA_BYTES-1-8*i -: 8];
        end else begin : g_no_data
            assign data_byte[i] = 8'h00;
        end
        if (i < 4) begin : g_crc
            assign crc_byte[i] = crc[31-8*i -: 8];
        end else begin : g_no_crc
            assign crc_byte[i] = 8'h00;
        end
    end

    // Table k advances a byte through k further zero bytes.
    for (genvar k = 0; k < DATA_BYTES; k++) begin : g_tbl
        crc_slice_table #(
            .POLY       (POLY),
            .ZERO_BYTES (k)
        ) u_tbl (
            .index (tbl_idx[k]),
            .entry (tbl_out[k])
        );
    end

    // Effective byte count: full beat unless a last beat names a legal count.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        n_eff = 4'(DATA_BYTES);
        if (s_last && (s_nbytes != '0) && (4'(s_nbytes) <= 4'(DATA_BYTES))) begin
            n_eff = 4'(s_nbytes);
        end
    end

    // Table k looks up byte n-1-k, so the last byte of the beat uses table 0.
    always_comb begin
        for (int k = 0; k < DATA_BYTES; k++) begin
            tbl_idx[k] = 8'h00;
            if (4'(k) < n_eff) begin
                tbl_idx[k] = data_byte[3'(n_eff - 4'(k) - 4'd1)]
                           ^ crc_byte[3'(n_eff - 4'(k) - 4'd1)];
            end
        end
    end

    // Next CRC: surviving register bits shifted past the beat, XOR the lookups.
    always_comb begin
        case (n_eff)
            4'd1:    crc_next = {crc[23:0], 8'h00};
            4'd2:    crc_next = {crc[15:0], 16'h0000};
            4'd3:    crc_next = {crc[7:0], 24'h000000};
            default: crc_next = 32'h00000000;
        endcase
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (4'(k) < n_eff) begin
                crc_next = crc_next ^ tbl_out[k];
            end
        end
    end

    // Frame state and result register; clear outranks a same-cycle beat.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc      <= INIT;
            m_valid  <= 1'b0;
            m_crc    <= 32'h00000000;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (clear) begin
                crc     <= INIT;
                m_valid <= 1'b0;
            end else begin
                if (m_valid && m_ready) begin
                    m_valid <= 1'b0;
                end
                if (accept) begin
                    if (s_last) begin
                        crc     <= INIT;
                        m_crc   <= crc_next ^ XOROUT;
                        m_valid <= 1'b1;
                    end else begin
                        crc <= crc_next;
                    end
                end
            end
        end
    end

endmodule
